// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: request fields in, accept strobe
// and registered completion (rvalid/rdata/err) back out.
interface data_mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  ack, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rvalid, rdata, err
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between a CPU port (r0)
// and a loader/DMA port (r1); bounded bursts, bad-address rejection, 1-cycle completion.
module data_mem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 2048,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    data_mem_arbiter_if.slave r0,
    data_mem_arbiter_if.slave r1,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(64'd4 * 64'(MEM_WORDS));

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [1:0]        req_w;
    logic [1:0]        we_w;
    logic [ADDR_W-1:0] addr_w  [2];
    logic [DATA_W-1:0] wdata_w [2];
    logic [1:0]        ack_w;

    logic              gnt_valid;
    logic              gnt_sel;
    logic [ADDR_W-1:0] sel_addr;
    logic              addr_ok;

    logic [1:0]        rvalid_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rdata_q [2];

    assign req_w      = {r1.req, r0.req};
    assign we_w       = {r1.we, r0.we};
    assign addr_w[0]  = r0.addr;
    assign addr_w[1]  = r1.addr;
    assign wdata_w[0] = r0.wdata;
    assign wdata_w[1] = r1.wdata;

    // Contention: the owner keeps the port until its burst count saturates;
    // from IDLE the port that did not win last time goes first.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_sel   = 1'b0;
        if (!reset) begin
            if (req_w == 2'b01) begin
                gnt_valid = 1'b1;
                gnt_sel   = 1'b0;
            end else if (req_w == 2'b10) begin
                gnt_valid = 1'b1;
                gnt_sel   = 1'b1;
            end else if (req_w == 2'b11) begin
                gnt_valid = 1'b1;
                case (state_q)
                    OWN0:    gnt_sel = (count_q < BURST_MAX) ? 1'b0 : 1'b1;
                    OWN1:    gnt_sel = (count_q < BURST_MAX) ? 1'b1 : 1'b0;
                    default: gnt_sel = ~last_q;
                endcase
            end
        end
    end

    assign sel_addr = addr_w[gnt_sel];
    assign addr_ok  = (sel_addr[1:0] == 2'b00) && ({1'b0, sel_addr} < ADDR_LIMIT);
    assign mem_a    = gnt_valid ? sel_addr : '0;
    assign mem_wd   = gnt_valid ? wdata_w[gnt_sel] : '0;
    assign mem_we   = gnt_valid & we_w[gnt_sel] & addr_ok;

    always_comb begin
        state_d = IDLE;
        last_d  = last_q;
        count_d = '0;
        if (gnt_valid) begin
            state_d = gnt_sel ? OWN1 : OWN0;
            last_d  = gnt_sel;
            if (state_q == state_d)
                count_d = (count_q == BURST_MAX) ? count_q : count_q + CNT_W'(1);
            else
                count_d = CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign ack_w[gi] = gnt_valid && (gnt_sel == 1'(gi));

            // Completion register: read data only for good-address reads, zero otherwise.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid_q[gi] <= 1'b0;
                    err_q[gi]    <= 1'b0;
                    rdata_q[gi]  <= '0;
                end else begin
                    rvalid_q[gi] <= ack_w[gi];
                    err_q[gi]    <= ack_w[gi] & ~addr_ok;
                    rdata_q[gi]  <= (ack_w[gi] && !we_w[gi] && addr_ok) ? mem_rd : '0;
                end
            end
        end
    endgenerate

    assign r0.ack    = ack_w[0];
    assign r0.rvalid = rvalid_q[0];
    assign r0.rdata  = rdata_q[0];
    assign r0.err    = err_q[0];
    assign r1.ack    = ack_w[1];
    assign r1.rvalid = rvalid_q[1];
    assign r1.rdata  = rdata_q[1];
    assign r1.err    = err_q[1];
endmodule
